end_screen_ctrl: RTL and testbench
==================================

Name: end_screen_ctrl

Overview:
Controller that sequences the 224x256, 4-bit end-of-game image ROMs (lose and win images, one-cycle registered read) onto the 640x480 VGA raster. On a lose or win event it selects the image ROM, reveals the image top-down a band of rows per frame, holds it for a fixed number of frames, then waits for a keypress before signalling the game to restart. It sits between the VGA controller/color mapper and the image ROMs, and generates ROM addresses plus an overlay-valid strobe aligned with ROM data.

Parameters:
IMG_W, 224, image width in pixels
IMG_H, 256, image height in pixels
X0, 208, screen X of image left edge ((640-224)/2)
Y0, 112, screen Y of image top edge ((480-256)/2)
WIPE_STEP, 8, rows revealed per frame during the wipe
HOLD_FRAMES, 180, frames held before a key is accepted (3 s at 60 Hz)

Ports:
Clk  input  1  system/pixel clock
Reset_n  input  1  synchronous, active-low reset
DrawX  input  10  current raster X (0..639)
DrawY  input  10  current raster Y (0..479)
frame_start  input  1  one-cycle pulse at start of each frame (vsync edge)
lose_evt  input  1  one-cycle pulse: frog lost last life
win_evt  input  1  one-cycle pulse: all homes filled
key_any  input  1  level: any keyboard key pressed
rom_addr  output  16  address to both image ROMs
rom_sel  output  1  0 = lose image, 1 = win image (selects ROM data mux)
overlay_valid  output  1  high when the ROM data on this cycle is an image pixel to draw
overlay_on  output  1  high in any state except IDLE (game logic freezes)
screen_done  output  1  one-cycle pulse on leaving WAIT_KEY
state_dbg  output  2  current state encoding, for LEDs/hex display

Behaviour:
- Reset (Reset_n low at a Clk edge): state IDLE, reveal_rows=0, frame_cnt=0, rom_addr=0, rom_sel=0, overlay_valid=0, overlay_on=0, screen_done=0, pipeline valid bits cleared. A reset in the middle of any state returns to IDLE with no screen_done pulse.
- States (state_dbg encoding): IDLE=0, WIPE=1, HOLD=2, WAIT_KEY=3.
- IDLE: lose_evt -> rom_sel<=0, reveal_rows<=0, go WIPE. Else win_evt -> rom_sel<=1, same. Both in the same cycle -> lose wins. Events are ignored in every other state.
- WIPE: on each frame_start, reveal_rows <= min(reveal_rows+WIPE_STEP, IMG_H). On the frame_start where reveal_rows already equals IMG_H, go HOLD with frame_cnt<=0 (the fully revealed image shows for one complete frame before HOLD). With the defaults the wipe covers 32 frames plus 1.
- HOLD: each frame_start increments frame_cnt; when the increment reaches HOLD_FRAMES, go WAIT_KEY. key_any is ignored.
- WAIT_KEY: a key_any that was low for at least one cycle since entering this state, and is then high, starts the exit (rising-edge detect, so a key already held does not skip the screen). The exit pulses screen_done for 1 cycle and goes IDLE, with reveal_rows<=0.
- rom_sel holds its value through IDLE after exit, until the next event.
- Address pipeline (fixed latency):
  - Cycle t: DrawX/DrawY sampled. in_win = (state!=IDLE) && X0<=DrawX<X0+IMG_W && Y0<=DrawY<Y0+reveal_rows.
  - Cycle t+1: rom_addr = (DrawY-Y0)*IMG_W + (DrawX-X0) if in_win, else 0. The registered valid bit v1=in_win.
  - Cycle t+2: ROM data_Out is valid and overlay_valid=v1 delayed one cycle.
- Width rules: row offset is 8 bits and column offset is 8 bits, computed as unsigned differences only when in_win. Product and sum fit 16 bits; the maximum address is 255*224+223 = 57343. No wrap is permitted.
- overlay_on is registered and asserts the cycle after the event.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles with lose_evt pulsed -> all outputs 0, state_dbg=0 afterwards.
- Address mapping: force HOLD (rom_sel=0), DrawX=208, DrawY=112 at t -> rom_addr=0 at t+1, overlay_valid=1 at t+2. DrawX=431, DrawY=367 -> rom_addr=57343. DrawX=432 or DrawY=111 -> rom_addr=0, overlay_valid=0.
- Wipe: lose_evt then 1 frame_start -> pixel at DrawY=119 valid and DrawY=120 invalid. After 32 frame_starts all 256 rows are valid. The 33rd frame_start moves state_dbg to 2.
- Priority/ignore: lose_evt and win_evt in the same cycle -> rom_sel=0. win_evt during WIPE -> no change to rom_sel or state.
- Hold/exit: key_any held high from the event onward -> remains in WAIT_KEY after 180 frames. Release then press -> screen_done is a single 1-cycle pulse, state_dbg=0, overlay_on=0 next cycle.
- Mid-operation reset: assert Reset_n=0 during HOLD -> IDLE, no screen_done. A following win_evt restarts the wipe from 0 rows with rom_sel=1.

Source files
------------

// File: rtl/end_screen_if.sv
// End-screen image bus.
// Groups the raster position coming from the VGA controller with the address,
// image select and overlay strobe going towards the image ROMs / color mapper.
//   DrawX, DrawY   : current raster position (0..639, 0..479)
//   frame_start    : one-cycle pulse at the start of each frame
//   rom_addr       : pixel address into the 224x256 image ROMs
//   rom_sel        : 0 = lose image, 1 = win image
//   overlay_valid  : ROM data on this cycle is an image pixel to draw
// master: the end-screen controller; slave: the raster / ROM / color side.
interface end_screen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic [15:0] rom_addr;
  logic        rom_sel;
  logic        overlay_valid;

  modport master (
    input  DrawX, DrawY, frame_start,
    output rom_addr, rom_sel, overlay_valid
  );

  modport slave (
    output DrawX, DrawY, frame_start,
    input  rom_addr, rom_sel, overlay_valid
  );
endinterface

// File: rtl/end_screen_ctrl.sv
// End-of-game screen controller.
// On a lose or win event, selects the matching image ROM, reveals the image
// top-down WIPE_STEP rows per frame, holds it for HOLD_FRAMES frames, then
// waits for a fresh keypress and pulses screen_done so the game restarts.
// Generates ROM addresses for the centred image window with an overlay strobe
// aligned to the one-cycle registered ROM read.
// Ports:
//   Clk, Reset_n  : clock, synchronous active-low reset
//   img           : raster in, ROM address / select / overlay strobe out
//   lose_evt      : pulse, frog lost its last life
//   win_evt       : pulse, all homes filled
//   key_any       : level, any key pressed
//   overlay_on    : high whenever the end screen owns the display
//   screen_done   : one-cycle pulse on leaving the key-wait state
//   state_dbg     : current state (0 idle, 1 wipe, 2 hold, 3 wait key)
module end_screen_ctrl #(
  parameter int IMG_W       = 224,
  parameter int IMG_H       = 256,
  parameter int X0          = 208,
  parameter int Y0          = 112,
  parameter int WIPE_STEP   = 8,
  parameter int HOLD_FRAMES = 180
) (
  input  logic               Clk,
  input  logic               Reset_n,
  end_screen_if.master       img,
  input  logic               lose_evt,
  input  logic               win_evt,
  input  logic               key_any,
  output logic               overlay_on,
  output logic               screen_done,
  output logic [1:0]         state_dbg
);

  localparam logic [9:0]  X_LO     = 10'(X0);
  localparam logic [9:0]  X_HI     = 10'(X0 + IMG_W);
  localparam logic [9:0]  Y_LO     = 10'(Y0);
  localparam logic [8:0]  ROWS_MAX = 9'(IMG_H);
  localparam logic [9:0]  STEP     = 10'(WIPE_STEP);
  localparam logic [7:0]  HOLD_N   = 8'(HOLD_FRAMES);
  localparam logic [15:0] W16      = 16'(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WIPE     = 2'd1,
    S_HOLD     = 2'd2,
    S_WAIT_KEY = 2'd3
  } state_t;

  state_t      state;
  logic [8:0]  reveal_rows;
  logic [7:0]  frame_cnt;
  logic        key_armed;
  logic        rom_sel_q;

  logic        vld_p0;
  logic [15:0] addr_p0;
  logic [15:0] rom_addr_p1;
  logic        vld_p1;
  logic        vld_p2;

  // Row/column offsets are only meaningful inside the window, where both fit
  // in 8 bits; the largest address (255*224+223) still fits in 16 bits.
  function automatic logic [15:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    logic [7:0] row;
    logic [7:0] col;
    row = 8'(y - Y_LO);
    col = 8'(x - X_LO);
    return 16'(row) * W16 + 16'(col);
  endfunction

  // Next wipe extent, clamped at the full image height.
  function automatic logic [8:0] wipe_next(input logic [8:0] rows);
    logic [9:0] sum;
    sum = {1'b0, rows} + STEP;
    return (sum >= {1'b0, ROWS_MAX}) ? ROWS_MAX : sum[8:0];
  endfunction

  always_comb begin
    vld_p0  = (state != S_IDLE) &&
              (img.DrawX >= X_LO) && (img.DrawX < X_HI) &&
              (img.DrawY >= Y_LO) && (img.DrawY < (Y_LO + {1'b0, reveal_rows}));
    addr_p0 = '0;
    if (vld_p0) addr_p0 = pix_addr(img.DrawX, img.DrawY);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr_p1 <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
    end else begin
      // stage 0 -> 1: ROM address presented, ROM read starts
      rom_addr_p1 <= addr_p0;
      vld_p1      <= vld_p0;
      // stage 1 -> 2: ROM data out, strobe aligned with it
      vld_p2      <= vld_p1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      reveal_rows <= '0;
      frame_cnt   <= '0;
      key_armed   <= 1'b0;
      rom_sel_q   <= 1'b0;
      overlay_on  <= 1'b0;
      screen_done <= 1'b0;
    end else begin
      screen_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // lose takes priority over win when both arrive together
          if (lose_evt) begin
            rom_sel_q   <= 1'b0;
            reveal_rows <= '0;
            overlay_on  <= 1'b1;
            state       <= S_WIPE;
          end else if (win_evt) begin
            rom_sel_q   <= 1'b1;
            reveal_rows <= '0;
            overlay_on  <= 1'b1;
            state       <= S_WIPE;
          end
        end
        S_WIPE: begin
          // the fully revealed image gets one whole frame before HOLD
          if (img.frame_start) begin
            if (reveal_rows == ROWS_MAX) begin
              frame_cnt <= '0;
              state     <= S_HOLD;
            end else begin
              reveal_rows <= wipe_next(reveal_rows);
            end
          end
        end
        S_HOLD: begin
          if (img.frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (frame_cnt + 8'd1 == HOLD_N) begin
              key_armed <= 1'b0;
              state     <= S_WAIT_KEY;
            end
          end
        end
        S_WAIT_KEY: begin
          // a key already held on entry must be released before it counts
          if (key_armed && key_any) begin
            screen_done <= 1'b1;
            overlay_on  <= 1'b0;
            reveal_rows <= '0;
            state       <= S_IDLE;
          end else if (!key_any) begin
            key_armed <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign img.rom_addr      = rom_addr_p1;
  assign img.overlay_valid = vld_p2;
  assign img.rom_sel       = rom_sel_q;
  assign state_dbg         = state;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Randomized scoreboard bench for end_screen_ctrl. The stimulus process drives
// one cycle at a time, consults a frame-count based reference model and queues
// the expected outputs with the cycle they are due; a monitor on the falling
// edge compares every due item against the DUT.
module tb_end_screen_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       lose_evt = 1'b0;
  logic       win_evt = 1'b0;
  logic       key_any = 1'b0;
  logic       overlay_on;
  logic       screen_done;
  logic [1:0] state_dbg;

  end_screen_if img();

  end_screen_ctrl dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .img        (img),
    .lose_evt   (lose_evt),
    .win_evt    (win_evt),
    .key_any    (key_any),
    .overlay_on (overlay_on),
    .screen_done(screen_done),
    .state_dbg  (state_dbg)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int kind;
    int val;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string kname[6] = '{"rom_addr", "overlay_valid", "state_dbg", "rom_sel", "overlay_on", "screen_done"};

  // Reference model: the end screen is described by whether it is active and
  // how many frame starts have been seen since the triggering event.
  bit m_active = 1'b0;
  bit m_sel    = 1'b0;
  bit m_armed  = 1'b0;
  bit m_done   = 1'b0;
  int m_n      = 0;
  bit prev_iw  = 1'b0;

  function automatic int rows_of(int n);
    return (8 * n > 256) ? 256 : 8 * n;
  endfunction

  // 0..32 frame starts: wiping; next 180: holding; after that: waiting for a key
  function automatic int phase_of(int n);
    if (n <= 32)  return 1;
    if (n <= 212) return 2;
    return 3;
  endfunction

  function automatic int actual(int kind);
    case (kind)
      0:       return int'(img.rom_addr);
      1:       return int'(img.overlay_valid);
      2:       return int'(state_dbg);
      3:       return int'(img.rom_sel);
      4:       return int'(overlay_on);
      default: return int'(screen_done);
    endcase
  endfunction

  task automatic do_check(input exp_t e);
    int a;
    a = actual(e.kind);
    n_checks++;
    if (a == e.val) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", kname[e.kind], cyc, a, e.val);
  endtask

  always @(negedge Clk) begin
    exp_t keep[$];
    keep.delete();
    foreach (exp_q[i]) begin
      if (exp_q[i].due <= cyc) do_check(exp_q[i]);
      else keep.push_back(exp_q[i]);
    end
    exp_q = keep;
  end

  task automatic push(input int kind, input int val);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit lose, input bit win, input bit key,
                      input bit fs, input int x, input int y);
    bit iw;
    @(negedge Clk);
    Reset_n         = rst;
    lose_evt        = lose;
    win_evt         = win;
    key_any         = key;
    img.frame_start = fs;
    img.DrawX       = 10'(x);
    img.DrawY       = 10'(y);

    iw = rst && m_active && (x >= 208) && (x < 432) && (y >= 112) && (y < 112 + rows_of(m_n));
    push(0, iw ? (y - 112) * 224 + (x - 208) : 0);
    push(1, rst ? int'(prev_iw) : 0);
    prev_iw = iw;

    if (!rst) begin
      m_active = 1'b0; m_n = 0; m_sel = 1'b0; m_armed = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (lose) begin
          m_active = 1'b1; m_n = 0; m_sel = 1'b0;
        end else if (win) begin
          m_active = 1'b1; m_n = 0; m_sel = 1'b1;
        end
      end else if (phase_of(m_n) == 3) begin
        if (m_armed && key) begin
          m_active = 1'b0; m_done = 1'b1;
        end else if (!key) begin
          m_armed = 1'b1;
        end
      end else if (fs) begin
        m_n++;
        if (phase_of(m_n) == 3) m_armed = 1'b0;
      end
    end

    push(2, m_active ? phase_of(m_n) : 0);
    push(3, int'(m_sel));
    push(4, int'(m_active));
    push(5, int'(m_done));
  endtask

  function automatic int rx();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 639));
    return int'($urandom_range(204, 436));
  endfunction

  function automatic int ry();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 479));
    return int'($urandom_range(108, 372));
  endfunction

  // kmode: 0 key low, 1 key high, 2 random key and stray events
  function automatic bit kbit(int kmode);
    if (kmode == 2) return bit'($urandom_range(0, 1));
    return bit'(kmode == 1);
  endfunction

  function automatic bit rev(int kmode);
    if (kmode == 2) return bit'($urandom_range(0, 7) == 0);
    return 1'b0;
  endfunction

  task automatic frames(input int nf, input int kmode);
    for (int f = 0; f < nf; f++) begin
      step(1, rev(kmode), rev(kmode), kbit(kmode), 1, rx(), ry());
      repeat ($urandom_range(1, 4)) step(1, rev(kmode), rev(kmode), kbit(kmode), 0, rx(), ry());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d expected the run to finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    img.DrawX       = '0;
    img.DrawY       = '0;
    img.frame_start = 1'b0;

    // Reset held three cycles with a lose event inside it
    step(0, 0, 0, 0, 0, 300, 200);
    step(0, 1, 0, 0, 0, 300, 200);
    step(0, 0, 0, 0, 0, 300, 200);

    // Idle: nothing in the window is valid, frame starts do nothing
    repeat (6) step(1, 0, 0, 0, 0, rx(), ry());
    step(1, 0, 0, 0, 1, 300, 200);

    // Lose and win together: lose image; key held high from here on
    step(1, 1, 1, 1, 0, 300, 200);
    step(1, 0, 0, 1, 0, 208, 112);
    step(1, 0, 0, 1, 1, rx(), ry());
    step(1, 0, 0, 1, 0, 208, 119);
    step(1, 0, 0, 1, 0, 208, 120);
    step(1, 0, 1, 1, 0, 300, 115);
    step(1, 1, 0, 1, 0, 431, 119);

    // Remaining 31 wipe frames, then the full image is visible
    frames(31, 1);
    step(1, 0, 0, 1, 0, 431, 367);
    step(1, 0, 0, 1, 0, 208, 367);

    // 33rd frame start moves to hold; window corners and just-outside pixels
    frames(1, 1);
    step(1, 0, 0, 1, 0, 208, 112);
    step(1, 0, 0, 1, 0, 431, 367);
    step(1, 0, 0, 1, 0, 432, 200);
    step(1, 0, 0, 1, 0, 300, 111);
    step(1, 0, 0, 1, 0, 207, 300);
    step(1, 0, 0, 1, 0, 300, 368);

    // Hold for 180 frames with the key still held, then stay waiting
    frames(180, 1);
    repeat (5) step(1, 0, 0, 1, 0, rx(), ry());

    // Release then press: single done pulse, back to idle
    step(1, 0, 0, 0, 0, rx(), ry());
    step(1, 0, 0, 1, 0, rx(), ry());
    repeat (4) step(1, 0, 0, 1, 0, rx(), ry());
    step(1, 0, 0, 0, 0, 300, 200);

    // Win run with random key and stray events, reset in the middle of hold
    step(1, 0, 1, 0, 0, rx(), ry());
    frames(38, 2);
    step(1, 0, 0, 0, 0, 300, 200);
    step(0, 0, 0, 1, 0, 300, 200);
    repeat (3) step(1, 0, 0, kbit(2), 0, rx(), ry());

    // Win restarts the wipe from zero rows with the win image
    step(1, 0, 1, 0, 0, 300, 200);
    step(1, 0, 0, 0, 0, 208, 112);
    step(1, 0, 0, 0, 1, 300, 119);
    step(1, 0, 0, 0, 0, 300, 119);
    step(1, 0, 0, 0, 0, 300, 120);
    frames(4, 2);
    repeat (3) step(1, 0, 0, 0, 0, 300, 150);

    repeat (3) @(negedge Clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d expected=0 items left", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
